// File: rtl/wfunc_apb_loader.sv
// wfunc_apb_loader: APB initiator that arms the window-function block.
// Soft-resets the window FSM, streams FFT_SIZE coefficients from a
// valid/ready source into window registers, issues CHANGE STATE, then
// polls STATUS until the window block reports WAIT (or gives up).
module wfunc_apb_loader #(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1)+3,
  parameter int POLL_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              coef_tvalid,
  output logic              coef_tready,
  input  logic [31:0]       coef_tdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(FFT_SIZE);
  localparam int PC_W  = $clog2(POLL_MAX+1);
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE+1)*4);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FFT_SIZE-1);
  localparam logic [PC_W-1:0]   POLL_LAST = PC_W'(POLL_MAX-1);
  localparam logic [PC_W-1:0]   POLL_SAT  = PC_W'(POLL_MAX);

  typedef enum logic [3:0] {
    IDLE, SRST, LWAIT, LSET, LACC, CHG, PGAP, POLL, DONE, ERR
  } state_t;

  state_t            state, state_d;
  logic [1:0]        ph, ph_d;          // phase inside multi-cycle states
  logic [IDX_W-1:0]  idx, idx_d;
  logic [PC_W-1:0]   poll_cnt, poll_cnt_d;
  logic [APB_AW-1:0] paddr_d;
  logic [31:0]       pwdata_d;

  // Only the WAIT field of STATUS matters here.
  logic unused_prdata;
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};

  assign busy  = !(state == IDLE || state == DONE || state == ERR);
  assign done  = (state == DONE);
  assign error = (state == ERR);

  // State, counters and the held APB address/data; reset kills any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ph       <= '0;
      idx      <= '0;
      poll_cnt <= '0;
      paddr    <= '0;
      pwdata   <= '0;
    end else begin
      state    <= state_d;
      ph       <= ph_d;
      idx      <= idx_d;
      poll_cnt <= poll_cnt_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
    end
  end

  // Next-state and APB strobes. Address/data are loaded one cycle before
  // setup so they are stable across setup and access.
  always_comb begin
    state_d     = state;
    ph_d        = ph;
    idx_d       = idx;
    poll_cnt_d  = poll_cnt;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    coef_tready = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = SRST;
          ph_d       = '0;
          idx_d      = '0;
          poll_cnt_d = '0;
          paddr_d    = CTRL_ADDR;
          pwdata_d   = 32'h0000_0001;
        end
      end
      SRST: begin
        psel    = 1'b1;
        pwrite  = 1'b1;
        penable = ph[0];
        ph_d    = ph[0] ? 2'd0 : 2'd1;
        if (ph[0]) state_d = LWAIT;
      end
      LWAIT: begin
        coef_tready = 1'b1;
        if (coef_tvalid) begin
          pwdata_d = coef_tdata;
          paddr_d  = APB_AW'({idx, 2'b00});
          state_d  = LSET;
        end
      end
      LSET: begin
        psel    = 1'b1;
        pwrite  = 1'b1;
        state_d = LACC;
      end
      LACC: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        if (idx == IDX_LAST) begin
          state_d  = CHG;
          ph_d     = '0;
          paddr_d  = CTRL_ADDR;
          pwdata_d = 32'h0000_0100;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = LWAIT;
        end
      end
      // ph 0: bus-idle gap after the last word, 1: setup, 2: access
      CHG: begin
        psel    = (ph != 2'd0);
        pwrite  = (ph != 2'd0);
        penable = (ph == 2'd2);
        ph_d    = ph + 2'd1;
        if (ph == 2'd2) begin
          ph_d    = '0;
          state_d = PGAP;
        end
      end
      PGAP: begin
        paddr_d  = STAT_ADDR;
        pwdata_d = '0;
        ph_d     = '0;
        state_d  = POLL;
      end
      POLL: begin
        psel    = 1'b1;
        penable = ph[0];
        ph_d    = ph[0] ? 2'd0 : 2'd1;
        if (ph[0]) begin
          if (prdata[9:8] == 2'b01) begin
            state_d = DONE;
          end else if (poll_cnt == POLL_LAST) begin
            poll_cnt_d = POLL_SAT;
            state_d    = ERR;
          end else begin
            poll_cnt_d = poll_cnt + 1'b1;
            state_d    = PGAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wfunc_apb_loader.sv
// Scoreboard bench for wfunc_apb_loader: a reference model expands each
// scenario into the expected APB transaction list; a negedge monitor pops
// and compares every access cycle and checks bus protocol rules.
module tb_wfunc_apb_loader;
  localparam int FFT = 8;
  localparam int PM  = 15;
  localparam int AW  = 6;
  localparam logic [AW-1:0] CTRL = 6'h20;
  localparam logic [AW-1:0] STAT = 6'h24;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic coef_tvalid = 1'b0, coef_tready;
  logic [31:0] coef_tdata = '0, prdata = '0, pwdata;
  logic psel, penable, pwrite, busy, done, error;
  logic [AW-1:0] paddr;

  always #5 clk = ~clk;

  wfunc_apb_loader #(.FFT_SIZE(FFT), .POLL_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .coef_tvalid(coef_tvalid), .coef_tready(coef_tready), .coef_tdata(coef_tdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [31:0]   data;
    int            fin;   // 0 none, 1 done expected next cycle, 2 error
  } txn_t;

  txn_t        exp_arr[64];
  int          exp_n = 0;
  int          exp_rd = 0;
  bit          exp_ok;
  logic [31:0] coefs[FFT];
  logic [31:0] resp[PM+2];
  int          src_mode = 0;
  int          gen = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  task automatic add(input logic [AW-1:0] a, input logic w, input logic [31:0] d, input int f);
    exp_arr[exp_n] = '{addr: a, wr: w, data: d, fin: f};
    exp_n++;
  endtask

  // Reference: whole sequence derived from the coefficient and status lists.
  task automatic build_model();
    int nreads;
    exp_n  = 0;
    exp_ok = 1'b0;
    add(CTRL, 1'b1, 32'h1, 0);
    for (int i = 0; i < FFT; i++) add(AW'(i*4), 1'b1, coefs[i], 0);
    add(CTRL, 1'b1, 32'h100, 0);
    nreads = PM;
    for (int r = 0; r < PM; r++)
      if (resp[r][9:8] == 2'b01) begin nreads = r + 1; exp_ok = 1'b1; break; end
    for (int r = 0; r < nreads; r++)
      add(STAT, 1'b0, 32'h0, (r == nreads-1) ? (exp_ok ? 1 : 2) : 0);
  endtask

  task automatic set_resp(input int fails, input logic [31:0] failv, input logic [31:0] okv);
    for (int r = 0; r < PM+2; r++) resp[r] = (r < fails) ? failv : okv;
  endtask

  task automatic rand_resp();
    int k;
    logic [31:0] v;
    logic [1:0] bad;
    k = $urandom_range(0, PM+1);
    for (int r = 0; r < PM+2; r++) begin
      v = $urandom;
      do bad = 2'($urandom_range(0, 3)); while (bad == 2'b01);
      v[9:8] = (r == k) ? 2'b01 : bad;
      resp[r] = v;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_seq(input int mode, input bit extra_starts);
    src_mode = mode;
    build_model();
    gen++;
    pulse_start();
    for (int c = 0; c < 3000 && !(done || error); c++) begin
      @(negedge clk);
      start = extra_starts && (c == 5 || c == 12 || c == 20);
    end
    start = 1'b0;
    chk("seq_timeout", 32'(done | error), 32'h1);
    @(negedge clk);
    chk("final_done", 32'(done), 32'(exp_ok));
    chk("final_error", 32'(error), 32'(!exp_ok));
    chk("final_busy", 32'(busy), 32'h0);
    chk("txn_count", 32'(exp_rd), 32'(exp_n));
  endtask

  // Coefficient source: idx advances after each observed handshake.
  initial begin : src_p
    int idx, sgen, cyc;
    bit hs, v;
    idx = 0; sgen = 0; cyc = 0; hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || sgen != gen) begin idx = 0; hs = 0; sgen = gen; end
      else if (hs) idx++;
      cyc++;
      case (src_mode)
        0:       v = 1'b1;
        1:       v = ((cyc / 5) % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      coef_tvalid = v && (idx < FFT);
      coef_tdata  = (idx < FFT) ? coefs[idx] : $urandom;
      hs = coef_tvalid && coef_tready;
    end
  end

  // STATUS responder: presents the next response from the setup cycle on.
  initial begin : rsp_p
    int rd, rgen;
    rd = 0; rgen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || rgen != gen) begin rd = 0; rgen = gen; end
      if (rst_n && psel && !penable && !pwrite) begin
        prdata = (rd < PM+2) ? resp[rd] : 32'h100;
        rd++;
      end
    end
  end

  // Monitor: protocol rules plus scoreboard pop on every access cycle.
  initial begin : mon_p
    int mgen, fin;
    logic pp, sw;
    logic [AW-1:0] sa;
    logic [31:0] sd;
    txn_t e;
    mgen = 0; fin = 0; pp = 0; sw = 0; sa = '0; sd = '0;
    forever begin
      @(negedge clk);
      if (mgen != gen) begin mgen = gen; exp_rd = 0; fin = 0; end
      if (!rst_n) begin fin = 0; pp = 0; continue; end
      if (fin != 0) begin
        chk("end_done", 32'(done), 32'(fin == 1));
        chk("end_error", 32'(error), 32'(fin == 2));
        chk("end_busy", 32'(busy), 32'h0);
        fin = 0;
      end
      if (psel && !penable) begin
        chk("gap_before_setup", 32'(pp), 32'h0);
        sa = paddr; sw = pwrite; sd = pwdata;
      end
      if (psel && penable) begin
        chk("stable_addr", 32'(paddr), 32'(sa));
        chk("stable_write", 32'(pwrite), 32'(sw));
        chk("stable_wdata", pwdata, sd);
        if (exp_rd >= exp_n) begin
          chk("unexpected_txn", 32'(exp_rd), 32'(exp_n));
        end else begin
          e = exp_arr[exp_rd];
          chk("txn_addr", 32'(paddr), 32'(e.addr));
          chk("txn_write", 32'(pwrite), 32'(e.wr));
          chk("txn_wdata", pwdata, e.data);
          fin = e.fin;
          exp_rd++;
        end
      end
      if (coef_tready) begin
        chk("tready_bus_idle", 32'(psel), 32'h0);
        chk("tready_busy", 32'(busy), 32'h1);
      end
      pp = psel;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit found;
    // reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_tready", 32'(coef_tready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal: always valid, status WAIT on first read
    for (int i = 0; i < FFT; i++) coefs[i] = 32'h0001_0000 + i;
    set_resp(0, 32'h0, 32'h100);
    run_seq(0, 1'b0);

    // stalling source
    for (int i = 0; i < FFT; i++) coefs[i] = $urandom;
    run_seq(1, 1'b0);

    // three not-ready polls
    set_resp(3, 32'h000, 32'h100);
    run_seq(0, 1'b0);

    // stuck status -> error, then restart
    set_resp(PM+2, 32'h200, 32'h200);
    run_seq(2, 1'b0);
    set_resp(0, 32'h0, 32'h100);
    run_seq(2, 1'b0);

    // reset during access of word 3
    for (int i = 0; i < FFT; i++) coefs[i] = $urandom;
    src_mode = 0;
    build_model();
    gen++;
    pulse_start();
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      found = psel && penable && pwrite && (paddr == AW'(12));
    end
    chk("word3_seen", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_psel", 32'(psel), 0);
    chk("arst_penable", 32'(penable), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tready", 32'(coef_tready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(0, 1'b0);

    // start pulses while busy are ignored
    for (int i = 0; i < FFT; i++) coefs[i] = 32'h0001_0000 + i;
    set_resp(0, 32'h0, 32'h100);
    run_seq(0, 1'b1);

    // randomized
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < FFT; i++) coefs[i] = $urandom;
      rand_resp();
      run_seq(2, 1'(t[0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
